cmd_frame_decoder: RTL and testbench
====================================

Name: cmd_frame_decoder

Overview:
- Parametrised successor to the single-byte UART command decoder. Decodes opcode and optional argument byte frames from the UART RX path into an OUT_W-bit output register.
- Sends one- or two-byte responses through the UART TX using a start/done handshake.
- Adds an inter-byte timeout and overrun detection.
- Sits between the RX synchroniser (valid/cmd_in) and the UART TX (tx_start/tx_data/tx_done).

Parameters:
- OUT_W, 8, width of output register out_reg; legal range 1..8.
- RESET_VAL, 0, value loaded into out_reg by reset and by the RESET opcode; width OUT_W.
- TIMEOUT_CYC, 100000, clock cycles allowed between opcode and argument byte; 0 disables the timeout.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- valid  in  1  one-cycle pulse: cmd_in holds a received byte.
- cmd_in  in  8  received byte.
- tx_done  in  1  one-cycle pulse from UART TX when the current byte has finished.
- tx_data  out  8  response byte; held stable from the tx_start pulse until tx_done.
- tx_start  out  1  one-cycle pulse that launches a TX byte.
- out_reg  out  OUT_W  controlled outputs; generalises the single LED bit.
- busy  out  1  high in every state except IDLE.
- overrun  out  1  sticky: a byte was dropped.
- state  out  3  debug view of the FSM state.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low; it is sampled only on the rising edge of clk.
- Reset values: tx_data=0x00, tx_start=0, out_reg=RESET_VAL, busy=0, overrun=0, state=IDLE. Reset mid-frame or mid-response aborts immediately; no further tx_start is issued.
- State encoding: IDLE=0, GET_ARG=1, EXEC=2, SEND=3, WAIT_DONE=4.
- Opcodes. ACK=0x55, NACK=0xEE, TMO=0xE0, RST_ACK=0xAA.
  - 0xA1 SET, with argument i: out_reg[i]<=1, respond ACK. If i>=OUT_W, out_reg is unchanged and the response is NACK.
  - 0xA2 CLR, with argument i: out_reg[i]<=0, respond ACK. Same range check as SET.
  - 0xA3 WRITE, with argument b: out_reg<=b[OUT_W-1:0], respond ACK.
  - 0xB1 READ, no argument: respond with two bytes, ACK then zero-extended out_reg.
  - 0xC1 RESET, no argument: out_reg<=RESET_VAL, overrun<=0, respond RST_ACK.
  - Any other opcode: respond NACK; no other effect.
- Transitions:
  - IDLE: on valid, latch the opcode. Go to GET_ARG for 0xA1–0xA3; otherwise go to EXEC.
  - GET_ARG: on valid, latch the argument and go to EXEC. The timer counts cycles since entry. When it reaches TIMEOUT_CYC with no valid, the response is TMO, out_reg is unchanged, and the FSM goes to SEND. If valid and the timeout occur in the same cycle, valid wins.
  - EXEC (one cycle): apply the register update, load the response queue (1 or 2 bytes, or up to 3 with the optional feature below), go to SEND.
  - SEND: tx_data<=current byte, tx_start<=1 for exactly one cycle, go to WAIT_DONE.
  - WAIT_DONE: on tx_done, go to SEND if bytes remain, else to IDLE. tx_done in any other state is ignored.
- Latency: valid for a no-argument opcode at edge N gives EXEC at N+1 and the tx_start pulse registered at N+2. For argument opcodes, count N from the argument's valid.
- Dropped bytes: valid in EXEC, SEND or WAIT_DONE drops the byte and sets overrun<=1; FSM state is unaffected. overrun is cleared only by rst_n or the RESET opcode.
- READ and out_reg: READ returns out_reg as it stands in EXEC, i.e. including all earlier updates.
- tx_data after a response: keeps its last value after returning to IDLE.

Optional Feature:
- Macro: CMD_ECHO_EN.
- Defined: every response is prefixed with an echo of the opcode byte. This applies to NACK and TMO cases too. READ becomes 3 bytes: opcode, ACK, value.
- Undefined: no echo; byte counts are exactly as listed above.
- Queue depth is 3 when defined, 2 when undefined.

Test Plan:
- Reset held 2 cycles with OUT_W=8, RESET_VAL=0x00 -> all outputs at reset values and state=0. Then send 0xB1 -> bytes 0x55, 0x00; tx_start pulses once per byte, each after tx_done.
- Send 0xA1 then 0x03 -> out_reg=0x08, response 0x55. Then 0xA2 then 0x03 -> out_reg=0x00, response 0x55. With OUT_W=4, 0xA1 then 0x05 -> response 0xEE, out_reg unchanged.
- Send 0xA3 then 0xC5, then 0xB1 -> out_reg=0xC5, responses 0x55, 0x55, 0xC5. Then 0xC1 -> out_reg=RESET_VAL, response 0xAA.
- TIMEOUT_CYC=16: send 0xA3 with no argument -> response 0xE0 exactly at timeout expiry, busy returns low after tx_done. Separately, argument valid in the same cycle as expiry -> executes normally.
- Send 0x7F -> response 0xEE. Pulse valid during WAIT_DONE -> overrun=1, response unaffected. Then 0xC1 -> overrun=0.
- Assert rst_n low during WAIT_DONE of a READ -> no second tx_start, all outputs at reset values. With CMD_ECHO_EN defined, 0xB1 -> bytes 0xB1, 0x55, value.

Source files
------------

// File: rtl/cmd_frame_decoder.sv
// Decodes opcode/argument byte frames into out_reg and replies over UART TX.
// Define CMD_ECHO_EN to prefix every response with an echo of the opcode.
module cmd_frame_decoder #(
  parameter int               OUT_W       = 8,
  parameter logic [OUT_W-1:0] RESET_VAL   = '0,
  parameter int               TIMEOUT_CYC = 100000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid,
  input  logic [7:0]       cmd_in,
  input  logic             tx_done,
  output logic [7:0]       tx_data,
  output logic             tx_start,
  output logic [OUT_W-1:0] out_reg,
  output logic             busy,
  output logic             overrun,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    GET_ARG   = 3'd1,
    EXEC      = 3'd2,
    SEND      = 3'd3,
    WAIT_DONE = 3'd4
  } state_t;

  localparam logic [7:0] OP_SET = 8'hA1;
  localparam logic [7:0] OP_CLR = 8'hA2;
  localparam logic [7:0] OP_WR  = 8'hA3;
  localparam logic [7:0] OP_RD  = 8'hB1;
  localparam logic [7:0] OP_RST = 8'hC1;

  localparam logic [7:0] R_ACK  = 8'h55;
  localparam logic [7:0] R_NACK = 8'hEE;
  localparam logic [7:0] R_TMO  = 8'hE0;
  localparam logic [7:0] R_RACK = 8'hAA;

`ifdef CMD_ECHO_EN
  localparam int QD = 3;
`else
  localparam int QD = 2;
`endif

  localparam logic [7:0] OUT_W8 = 8'(OUT_W);
  localparam bit TO_EN = (TIMEOUT_CYC > 0);
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] T_LAST =
    (TIMEOUT_CYC > 0) ? TW'(TIMEOUT_CYC - 1) : '0;

  state_t             st_q;
  logic [7:0]         op_q;
  logic [7:0]         arg_q;
  logic [TW-1:0]      timer;
  logic [QD-1:0][7:0] q_mem;
  logic [1:0]         q_len;
  logic [1:0]         q_idx;

  logic [OUT_W-1:0]   bmask;
  logic [7:0]         rd_val;
  logic [OUT_W-1:0]   out_nx;
  logic               clr_ovr;
  logic [7:0]         rsp0;
  logic [7:0]         rsp1;
  logic [1:0]         rsp_n;
  logic [QD-1:0][7:0] ld_q;
  logic [1:0]         ld_n;
  logic [QD-1:0][7:0] to_q;
  logic [1:0]         to_n;
  logic [7:0]         cur_byte;
  logic               arg_ok;
  logic               timeout_hit;
  logic               drop;

  assign state       = st_q;
  assign busy        = (st_q != IDLE);
  assign arg_ok      = (arg_q < OUT_W8);
  assign timeout_hit = TO_EN && (timer == T_LAST);
  assign drop        = valid &&
                       ((st_q == EXEC) ||
                        (st_q == SEND) ||
                        (st_q == WAIT_DONE));

  function automatic logic takes_arg(
    input logic [7:0] b
  );
    return (b == OP_SET) ||
           (b == OP_CLR) ||
           (b == OP_WR);
  endfunction

  // One-hot mask selecting the bit addressed by the argument byte
  always_comb begin
    bmask = '0;
    for (int i = 0; i < OUT_W; i++)
      bmask[i] = (arg_q == 8'(i));
  end

  // Zero-extended view of out_reg for the READ reply
  always_comb begin
    rd_val = '0;
    rd_val[OUT_W-1:0] = out_reg;
  end

  // Register update and reply bytes for the latched command
  always_comb begin
    out_nx  = out_reg;
    clr_ovr = 1'b0;
    rsp0    = R_NACK;
    rsp1    = 8'h00;
    rsp_n   = 2'd1;
    unique case (1'b1)
      (op_q == OP_SET): begin
        if (arg_ok) begin
          out_nx = out_reg | bmask;
          rsp0   = R_ACK;
        end
      end
      (op_q == OP_CLR): begin
        if (arg_ok) begin
          out_nx = out_reg & ~bmask;
          rsp0   = R_ACK;
        end
      end
      (op_q == OP_WR): begin
        out_nx = arg_q[OUT_W-1:0];
        rsp0   = R_ACK;
      end
      (op_q == OP_RD): begin
        rsp0  = R_ACK;
        rsp1  = rd_val;
        rsp_n = 2'd2;
      end
      (op_q == OP_RST): begin
        out_nx  = RESET_VAL;
        clr_ovr = 1'b1;
        rsp0    = R_RACK;
      end
      default: ;
    endcase
  end

  // Response queue images for normal execution and for a timeout
  always_comb begin
    ld_q = '0;
    to_q = '0;
`ifdef CMD_ECHO_EN
    ld_q[0] = op_q;
    ld_q[1] = rsp0;
    ld_q[2] = rsp1;
    ld_n    = rsp_n + 2'd1;
    to_q[0] = op_q;
    to_q[1] = R_TMO;
    to_n    = 2'd2;
`else
    ld_q[0] = rsp0;
    ld_q[1] = rsp1;
    ld_n    = rsp_n;
    to_q[0] = R_TMO;
    to_n    = 2'd1;
`endif
  end

  // Byte at the head of the response queue
  always_comb begin
    cur_byte = q_mem[0];
    for (int i = 1; i < QD; i++)
      if (q_idx == 2'(i))
        cur_byte = q_mem[i];
  end

  // Frame FSM with registered TX handshake, out_reg and overrun
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q     <= IDLE;
      op_q     <= '0;
      arg_q    <= '0;
      timer    <= '0;
      q_mem    <= '0;
      q_len    <= '0;
      q_idx    <= '0;
      tx_data  <= 8'h00;
      tx_start <= 1'b0;
      out_reg  <= RESET_VAL;
      overrun  <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      unique case (st_q)
        IDLE: begin
          if (valid) begin
            op_q  <= cmd_in;
            timer <= '0;
            st_q  <= takes_arg(cmd_in) ? GET_ARG : EXEC;
          end
        end
        GET_ARG: begin
          if (valid) begin
            arg_q <= cmd_in;
            st_q  <= EXEC;
          end else if (timeout_hit) begin
            q_mem <= to_q;
            q_len <= to_n;
            q_idx <= '0;
            st_q  <= SEND;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        EXEC: begin
          out_reg <= out_nx;
          if (clr_ovr)
            overrun <= 1'b0;
          q_mem <= ld_q;
          q_len <= ld_n;
          q_idx <= '0;
          st_q  <= SEND;
        end
        SEND: begin
          tx_data  <= cur_byte;
          tx_start <= 1'b1;
          st_q     <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (tx_done) begin
            if ((q_idx + 2'd1) < q_len) begin
              q_idx <= q_idx + 2'd1;
              st_q  <= SEND;
            end else begin
              st_q  <= IDLE;
            end
          end
        end
        default: st_q <= IDLE;
      endcase
      if (drop)
        overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cmd_frame_decoder.sv
// Random and directed frames against a transaction-level reply model.
// A second small instance covers OUT_W=4 and a disabled timeout.
module tb_cmd_frame_decoder;

  localparam int T = 16;
`ifdef CMD_ECHO_EN
  localparam int ECHO = 1;
`else
  localparam int ECHO = 0;
`endif

  logic       clk;
  logic       rst_n;
  logic       valid;
  logic [7:0] cmd_in;
  logic       tx_done;
  logic [7:0] tx_data;
  logic       tx_start;
  logic [7:0] out_reg;
  logic       busy;
  logic       overrun;
  logic [2:0] state;

  logic       rst4;
  logic       v4;
  logic [7:0] c4;
  logic       d4;
  logic [7:0] td4;
  logic       ts4;
  logic [3:0] o4;
  logic       b4;
  logic       ov4;
  logic [2:0] s4;

  cmd_frame_decoder #(
    .OUT_W(8), .RESET_VAL(8'h00), .TIMEOUT_CYC(T)
  ) dut (
    .clk(clk), .rst_n(rst_n), .valid(valid), .cmd_in(cmd_in),
    .tx_done(tx_done), .tx_data(tx_data), .tx_start(tx_start),
    .out_reg(out_reg), .busy(busy), .overrun(overrun), .state(state)
  );

  cmd_frame_decoder #(
    .OUT_W(4), .RESET_VAL(4'hA), .TIMEOUT_CYC(0)
  ) u4 (
    .clk(clk), .rst_n(rst4), .valid(v4), .cmd_in(c4),
    .tx_done(d4), .tx_data(td4), .tx_start(ts4),
    .out_reg(o4), .busy(b4), .overrun(ov4), .state(s4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] m_out = 8'h00;
  logic       m_ovr = 1'b0;

  task automatic chk(input bit ok, input string nm,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] b);
    valid  = 1'b1;
    cmd_in = b;
    step();
    valid  = 1'b0;
  endtask

  // Reply bytes and register effect of one frame, from the opcode table
  task automatic model(input logic [7:0] op, input logic [7:0] arg,
                       input bit tmo, output int n,
                       output logic [7:0] lastb);
    logic [7:0] r[$];
    if (ECHO == 1) r.push_back(op);
    if (tmo) begin
      r.push_back(8'hE0);
    end else begin
      case (op)
        8'hA1: if (arg < 8) begin
                 m_out = m_out | (8'd1 << arg);
                 r.push_back(8'h55);
               end else r.push_back(8'hEE);
        8'hA2: if (arg < 8) begin
                 m_out = m_out & ~(8'd1 << arg);
                 r.push_back(8'h55);
               end else r.push_back(8'hEE);
        8'hA3: begin m_out = arg; r.push_back(8'h55); end
        8'hB1: begin r.push_back(8'h55); r.push_back(m_out); end
        8'hC1: begin m_out = 8'h00; m_ovr = 1'b0; r.push_back(8'hAA); end
        default: r.push_back(8'hEE);
      endcase
    end
    n = r.size();
    lastb = r[n-1];
    foreach (r[i]) exp_q.push_back(r[i]);
  endtask

  task automatic wait_start(output int n);
    n = 0;
    while (!tx_start && n < 64) begin
      step();
      n++;
    end
    if (!tx_start) chk(1'b0, "tx_start_wait", 32'(n), 64);
  endtask

  // Drive one frame and play the TX side; dly=0 on an arg opcode = timeout
  task automatic do_frame(input logic [7:0] op, input logic [7:0] arg,
                          input int dly, input bit inj,
                          output logic [7:0] last, output int nb);
    bit isa;
    bit tmo;
    int ne;
    int n;
    int lat;
    int k;
    logic [7:0] el;
    isa = (op == 8'hA1) || (op == 8'hA2) || (op == 8'hA3);
    tmo = isa && (dly == 0);
    model(op, arg, tmo, ne, el);
    nb = 0;
    last = 8'h00;
    drive(op);
    lat = 2;
    if (isa) begin
      chk(state == 3'd1, "state_get_arg", 32'(state), 1);
      if (dly > 0) begin
        repeat (dly - 1) step();
        drive(arg);
      end else begin
        lat = T + 1;
      end
    end
    for (int i = 0; i < ne; i++) begin
      wait_start(n);
      if (!tx_start) break;
      chk(n == (i == 0 ? lat : 1), "tx_latency", 32'(n),
          32'(i == 0 ? lat : 1));
      last = tx_data;
      nb++;
      k = inj ? $urandom_range(1, 3) : $urandom_range(0, 3);
      for (int j = 0; j < k; j++) begin
        if (inj && j == 0) begin
          valid  = 1'b1;
          cmd_in = 8'($urandom);
        end
        step();
        if (valid) begin
          valid = 1'b0;
          m_ovr = 1'b1;
        end
      end
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
    end
    chk(nb == ne, "byte_count", 32'(nb), 32'(ne));
    chk(busy == 1'b0, "busy_idle", 32'(busy), 0);
    chk(state == 3'd0, "state_idle", 32'(state), 0);
    chk(tx_data == el, "tx_data_keep", 32'(tx_data), 32'(el));
  endtask

  task automatic u4_frame(input logic [7:0] op, input logic [7:0] arg,
                          input int dly, output logic [7:0] last,
                          output int n);
    int w;
    v4 = 1'b1; c4 = op; step(); v4 = 1'b0;
    if (dly > 0) begin
      repeat (dly - 1) step();
      v4 = 1'b1; c4 = arg; step(); v4 = 1'b0;
    end
    n = 0;
    last = 8'h00;
    for (int g = 0; g < 4; g++) begin
      w = 0;
      while (!ts4 && w < 64) begin step(); w++; end
      if (!ts4) begin
        chk(1'b0, "u4_tx_start_wait", 32'(w), 64);
        break;
      end
      last = td4;
      n++;
      d4 = 1'b1; step(); d4 = 1'b0;
      if (!b4) break;
    end
  endtask

  // Every tx_start byte and the state around it against the model
  logic       pend = 1'b0;
  logic [7:0] hold = 8'h00;
  always @(negedge clk) begin
    if (!rst_n) begin
      pend = 1'b0;
    end else if (tx_start) begin
      if (exp_q.size() == 0) begin
        chk(1'b0, "unexpected_tx_start", 32'(tx_data), 0);
      end else begin
        hold = exp_q.pop_front();
        chk(tx_data == hold, "tx_byte", 32'(tx_data), 32'(hold));
      end
      chk(out_reg == m_out, "out_reg_at_tx", 32'(out_reg), 32'(m_out));
      chk(overrun == m_ovr, "overrun_at_tx", 32'(overrun), 32'(m_ovr));
      chk(busy == 1'b1, "busy_at_tx", 32'(busy), 1);
      pend = 1'b1;
    end else if (pend) begin
      chk(tx_data == hold, "tx_data_stable", 32'(tx_data), 32'(hold));
      if (tx_done) pend = 1'b0;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] l;
    logic [7:0] op;
    logic [7:0] arg;
    int n;
    int dly;
    int r;
    int seen;

    rst_n = 1'b0; rst4 = 1'b0;
    valid = 1'b0; cmd_in = 8'h00; tx_done = 1'b0;
    v4 = 1'b0; c4 = 8'h00; d4 = 1'b0;
    step(); step();
    chk(tx_data == 8'h00, "rst_tx_data", 32'(tx_data), 0);
    chk(tx_start == 1'b0, "rst_tx_start", 32'(tx_start), 0);
    chk(out_reg == 8'h00, "rst_out_reg", 32'(out_reg), 0);
    chk(busy == 1'b0, "rst_busy", 32'(busy), 0);
    chk(overrun == 1'b0, "rst_overrun", 32'(overrun), 0);
    chk(state == 3'd0, "rst_state", 32'(state), 0);
    chk(o4 == 4'hA, "u4_rst_out", 32'(o4), 32'hA);
    rst_n = 1'b1; rst4 = 1'b1;
    step();

    do_frame(8'hB1, 8'h00, 0, 0, l, n);
    chk(n == 2 + ECHO, "read_len", 32'(n), 32'(2 + ECHO));
    chk(l == 8'h00, "read_val0", 32'(l), 0);
    do_frame(8'hA1, 8'h03, 3, 0, l, n);
    chk(out_reg == 8'h08, "set3", 32'(out_reg), 32'h08);
    chk(l == 8'h55, "set3_ack", 32'(l), 32'h55);
    do_frame(8'hA2, 8'h03, 1, 0, l, n);
    chk(out_reg == 8'h00, "clr3", 32'(out_reg), 0);
    do_frame(8'hA1, 8'h08, 2, 0, l, n);
    chk(l == 8'hEE, "set8_nack", 32'(l), 32'hEE);
    chk(out_reg == 8'h00, "set8_keep", 32'(out_reg), 0);
    do_frame(8'hA1, 8'h07, 5, 0, l, n);
    chk(out_reg == 8'h80, "set7", 32'(out_reg), 32'h80);
    do_frame(8'hA3, 8'hC5, 1, 0, l, n);
    chk(out_reg == 8'hC5, "write_c5", 32'(out_reg), 32'hC5);
    do_frame(8'hB1, 8'h00, 0, 0, l, n);
    chk(l == 8'hC5, "read_c5", 32'(l), 32'hC5);
    do_frame(8'hC1, 8'h00, 0, 0, l, n);
    chk(l == 8'hAA, "reset_ack", 32'(l), 32'hAA);
    chk(out_reg == 8'h00, "reset_out", 32'(out_reg), 0);
    do_frame(8'hA3, 8'h00, 0, 0, l, n);
    chk(l == 8'hE0, "timeout_tmo", 32'(l), 32'hE0);
    chk(n == 1 + ECHO, "timeout_len", 32'(n), 32'(1 + ECHO));
    do_frame(8'hA3, 8'h3C, T, 0, l, n);
    chk(l == 8'h55, "edge_arg_ack", 32'(l), 32'h55);
    chk(out_reg == 8'h3C, "edge_arg_out", 32'(out_reg), 32'h3C);
    do_frame(8'h7F, 8'h00, 0, 1, l, n);
    chk(l == 8'hEE, "unknown_nack", 32'(l), 32'hEE);
    chk(overrun == 1'b1, "overrun_set", 32'(overrun), 1);
    do_frame(8'hC1, 8'h00, 0, 0, l, n);
    chk(overrun == 1'b0, "overrun_clr", 32'(overrun), 0);

    u4_frame(8'hA1, 8'h05, 1, l, n);
    chk(l == 8'hEE, "u4_set5_nack", 32'(l), 32'hEE);
    u4_frame(8'hA1, 8'h04, 2, l, n);
    chk(l == 8'hEE, "u4_set4_nack", 32'(l), 32'hEE);
    chk(o4 == 4'hA, "u4_keep", 32'(o4), 32'hA);
    u4_frame(8'hA1, 8'h00, 1, l, n);
    chk(o4 == 4'hB, "u4_set0", 32'(o4), 32'hB);
    u4_frame(8'hA2, 8'h03, 1, l, n);
    chk(o4 == 4'h3, "u4_clr3", 32'(o4), 32'h3);
    u4_frame(8'hA3, 8'hF6, 1, l, n);
    chk(o4 == 4'h6, "u4_write", 32'(o4), 32'h6);
    u4_frame(8'hB1, 8'h00, 0, l, n);
    chk(l == 8'h06, "u4_read", 32'(l), 32'h06);
    chk(n == 2 + ECHO, "u4_read_len", 32'(n), 32'(2 + ECHO));
    u4_frame(8'hA1, 8'h00, 40, l, n);
    chk(l == 8'h55, "u4_no_timeout", 32'(l), 32'h55);
    chk(o4 == 4'h7, "u4_late_set", 32'(o4), 32'h7);
    u4_frame(8'hC1, 8'h00, 0, l, n);
    chk(o4 == 4'hA, "u4_reset_op", 32'(o4), 32'hA);

    for (int f = 0; f < 80; f++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1: op = 8'hA1;
        2, 3: op = 8'hA2;
        4, 9: op = 8'hA3;
        5, 6: op = 8'hB1;
        7:    op = 8'hC1;
        default: begin
          op = 8'($urandom);
          while (op inside {8'hA1, 8'hA2, 8'hA3, 8'hB1, 8'hC1})
            op = 8'($urandom);
        end
      endcase
      arg = (op == 8'hA3) ? 8'($urandom) : 8'($urandom_range(0, 11));
      r = $urandom_range(0, 9);
      dly = (r == 0) ? 0 : (r == 1) ? T : $urandom_range(1, T - 1);
      do_frame(op, arg, dly, ($urandom_range(0, 3) == 0), l, n);
    end

    do_frame(8'hA3, 8'h5A, 1, 1, l, n);
    chk(out_reg == 8'h5A, "pre_rst_out", 32'(out_reg), 32'h5A);
    model(8'hB1, 8'h00, 1'b0, n, l);
    drive(8'hB1);
    wait_start(n);
    chk(n == 2, "mid_rst_lat", 32'(n), 2);
    step();
    chk(state == 3'd4, "wait_done_state", 32'(state), 4);
    rst_n = 1'b0;
    exp_q.delete();
    m_out = 8'h00;
    m_ovr = 1'b0;
    step(); step();
    rst_n = 1'b1;
    chk(tx_data == 8'h00, "mid_rst_tx_data", 32'(tx_data), 0);
    chk(tx_start == 1'b0, "mid_rst_tx_start", 32'(tx_start), 0);
    chk(out_reg == 8'h00, "mid_rst_out", 32'(out_reg), 0);
    chk(busy == 1'b0, "mid_rst_busy", 32'(busy), 0);
    chk(overrun == 1'b0, "mid_rst_ovr", 32'(overrun), 0);
    chk(state == 3'd0, "mid_rst_state", 32'(state), 0);
    seen = 0;
    tx_done = 1'b1; step(); tx_done = 1'b0;
    repeat (12) begin
      step();
      if (tx_start) seen++;
    end
    chk(seen == 0, "no_tx_after_rst", 32'(seen), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
